// File: rtl/dmem_mmio.sv
// ---------------------------------------------------------------------------
// dmem_mmio
//
// Data-side memory for the CPU MEM stage. Every access is decoded to one of
// a word RAM, three MMIO registers or unmapped space. Reads are combinational.
// Writes commit on the rising clock edge. A write to TXDATA queues a byte in
// a small FIFO. An 8N1 UART transmitter drains that FIFO onto uart_tx_o.
// A free-running 32-bit cycle counter can be read through CYCLES.
//
// Memory map (word addresses):
//   0 .. RAM_DEPTH-1 : RAM
//   0xFFFF_FFF0      : TXDATA  (write pushes wdata[7:0]; reads 0)
//   0xFFFF_FFF4      : STATUS  {27'b0, overflow, busy, empty, full, 1'b0}
//                      (writing 1 to bit4 clears overflow)
//   0xFFFF_FFF8      : CYCLES  (any write loads 0)
//   anything else    : reads 0, writes ignored
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous active-high reset
//   mem_ctrl_i   in   2   bit0 = read, bit1 = write
//   mem_addr_i   in  32   word address
//   mem_wdata_i  in  32   store data
//   mem_rdata_o  out 32   load data (combinational, 0 when not reading)
//   uart_tx_o    out  1   serial TX line, idle high
//   tx_busy_o    out  1   transmitter active or FIFO non-empty
// ---------------------------------------------------------------------------
module dmem_mmio #(
  parameter int RAM_DEPTH    = 128,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  mem_ctrl_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        uart_tx_o,
  output logic        tx_busy_o
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FFF4;
  localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_FFF8;

  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  logic [31:0]       ram_q [RAM_DEPTH];
  logic [7:0]        fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       cycles_q, cycles_d;

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic              rd_en;
  logic              wr_en;
  logic              sel_ram;
  logic              sel_tx;
  logic              sel_status;
  logic              sel_cycles;
  logic [RAM_AW-1:0] ram_idx;

  always_comb begin
    rd_en      = mem_ctrl_i[0];
    wr_en      = mem_ctrl_i[1];
    sel_ram    = (mem_addr_i < 32'(RAM_DEPTH));
    sel_tx     = (mem_addr_i == ADDR_TXDATA);
    sel_status = (mem_addr_i == ADDR_STATUS);
    sel_cycles = (mem_addr_i == ADDR_CYCLES);
    ram_idx    = mem_addr_i[RAM_AW-1:0];
  end

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic push_req;
  logic fifo_push;
  logic ovf_set;

  always_comb begin
    fifo_full  = (cnt_q == FIFO_FULL_CNT);
    fifo_empty = (cnt_q == '0);
    // The transmitter is the only consumer; it pops whenever it sits in IDLE
    // with data waiting.
    fifo_pop   = (state_q == S_IDLE) && !fifo_empty;
    push_req   = wr_en && sel_tx;
    // A push into a full FIFO still fits when a pop frees a slot this edge.
    fifo_push  = push_req && (!fifo_full || fifo_pop);
    ovf_set    = push_req && fifo_full && !fifo_pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({fifo_push, fifo_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) ovf_d = 1'b1;
    if (wr_en && sel_status && mem_wdata_i[4]) ovf_d = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Cycle counter: a write always loads zero and overrides the increment
  // -------------------------------------------------------------------------
  always_comb begin
    if (wr_en && sel_cycles) cycles_d = '0;
    else                     cycles_d = cycles_q + 32'd1;
  end

  // -------------------------------------------------------------------------
  // UART transmitter FSM
  // -------------------------------------------------------------------------
  logic baud_done;

  always_comb begin
    baud_done = (baud_q == BAUD_LAST);
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line is decoded from the state register so an asynchronous reset
  // forces it high immediately.
  always_comb begin
    case (state_q)
      S_START: uart_tx_o = 1'b0;
      S_DATA:  uart_tx_o = shift_q[0];
      default: uart_tx_o = 1'b1;
    endcase
  end

  assign tx_busy_o = (state_q != S_IDLE) || !fifo_empty;

  // -------------------------------------------------------------------------
  // Read mux: purely current address + registered state, so a simultaneous
  // write is never visible until the following cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_rdata_o = '0;
    if (rd_en) begin
      if (sel_ram)         mem_rdata_o = ram_q[ram_idx];
      else if (sel_status) mem_rdata_o = {27'b0, ovf_q, tx_busy_o, fifo_empty, fifo_full, 1'b0};
      else if (sel_cycles) mem_rdata_o = cycles_q;
      else                 mem_rdata_o = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      cycles_q <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  // RAM contents are architecturally zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
    end else if (wr_en && sel_ram) begin
      ram_q[ram_idx] <= mem_wdata_i;
    end
  end

  // FIFO payload needs no reset: the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= mem_wdata_i[7:0];
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// ---------------------------------------------------------------------------
// tb_dmem_mmio: directed test of dmem_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change 1ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_dmem_mmio;

  localparam logic [31:0] A_TX  = 32'hFFFF_FFF0;
  localparam logic [31:0] A_ST  = 32'hFFFF_FFF4;
  localparam logic [31:0] A_CYC = 32'hFFFF_FFF8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  mem_ctrl_i = 2'b00;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [31:0] mem_rdata_o;
  logic        uart_tx_o;
  logic        tx_busy_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  dmem_mmio #(
    .RAM_DEPTH   (128),
    .FIFO_DEPTH  (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mem_ctrl_i (mem_ctrl_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .uart_tx_o  (uart_tx_o),
    .tx_busy_o  (tx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_ctrl_i  = 2'b10;
    mem_addr_i  = addr;
    mem_wdata_i = data;
    tick();
    mem_ctrl_i  = 2'b00;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    mem_ctrl_i = 2'b01;
    mem_addr_i = addr;
    #1;
    data = mem_rdata_o;
    mem_ctrl_i = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  frame;

    // ---------------- reset state ----------------
    #2 rst_i = 1'b1;
    #1;
    check("rst_tx", {31'b0, uart_tx_o}, 32'd1);
    check("rst_busy", {31'b0, tx_busy_o}, 32'd0);
    check("rst_rdata", mem_rdata_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    rd(A_ST, d);  check("rst_status", d, 32'h0000_0004);
    rd(A_CYC, d); check("rst_cycles", d, 32'd0);
    rd(32'd5, d); check("rst_ram5", d, 32'd0);

    // ---------------- RAM ----------------
    tick();
    mem_ctrl_i  = 2'b11;
    mem_addr_i  = 32'd5;
    mem_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("ram_rw_old", mem_rdata_o, 32'd0);
    tick();
    mem_ctrl_i = 2'b01;
    #1;
    check("ram_rd_new", mem_rdata_o, 32'hDEAD_BEEF);
    mem_ctrl_i = 2'b00;
    #1;
    check("rd_disabled", mem_rdata_o, 32'd0);
    rd(32'd200, d); check("unmapped_rd", d, 32'd0);
    rd(A_TX, d);    check("txdata_rd", d, 32'd0);
    wr(32'd200, 32'h1234_5678);
    rd(32'd72, d);  check("unmapped_wr_alias", d, 32'd0);

    // ---------------- cycle counter ----------------
    wr(A_CYC, 32'h5555_5555);
    repeat (10) tick();
    rd(A_CYC, d); check("cycles_10", d, 32'd10);
    force dut.cycles_q = 32'hFFFF_FFFF;
    #1 release dut.cycles_q;
    rd(A_CYC, d); check("cycles_max", d, 32'hFFFF_FFFF);
    tick();
    rd(A_CYC, d); check("cycles_wrap", d, 32'd0);

    // ---------------- UART frame 0xA5 ----------------
    tick();
    frame = {1'b1, 8'hA5, 1'b0};
    wr(A_TX, 32'h0000_00A5);
    check("tx_idle_after_push", {31'b0, uart_tx_o}, 32'd1);
    check("busy_after_push", {31'b0, tx_busy_o}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("frame_bit%0d_clk%0d", k / 4, k % 4), {31'b0, uart_tx_o}, {31'b0, frame[k / 4]});
    end
    check("busy_end_stop", {31'b0, tx_busy_o}, 32'd1);
    tick();
    check("busy_after_frame", {31'b0, tx_busy_o}, 32'd0);
    check("tx_idle_after_frame", {31'b0, uart_tx_o}, 32'd1);

    // ---------------- overflow (edges E1..E7) ----------------
    tick();
    for (int i = 0; i < 5; i++) wr(A_TX, 32'h10 + 32'(i));
    rd(A_ST, d); check("five_fit_status", d, 32'h0000_000A);
    wr(A_TX, 32'h99);
    rd(A_ST, d); check("overflow_set", d, 32'h0000_001A);
    wr(A_ST, 32'h10);
    rd(A_ST, d); check("overflow_clr", d, 32'h0000_000A);

    // First frame started at E2, so its STOP ends and IDLE is entered at E42;
    // the pop of the next byte happens at E43. Push exactly on that edge.
    repeat (35) tick();
    check("idle_gap_tx", {31'b0, uart_tx_o}, 32'd1);
    wr(A_TX, 32'h77);
    rd(A_ST, d); check("push_pop_full", d, 32'h0000_000A);
    check("second_start", {31'b0, uart_tx_o}, 32'd0);

    // ---------------- reset mid-frame (DATA state) ----------------
    repeat (6) tick();
    #2 rst_i = 1'b1;
    #1;
    check("midrst_tx", {31'b0, uart_tx_o}, 32'd1);
    check("midrst_busy", {31'b0, tx_busy_o}, 32'd0);
    rd(A_ST, d);  check("midrst_status", d, 32'h0000_0004);
    rd(32'd5, d); check("midrst_ram5", d, 32'd0);
    rst_i = 1'b0;
    repeat (3) tick();
    check("postrst_tx", {31'b0, uart_tx_o}, 32'd1);
    check("postrst_busy", {31'b0, tx_busy_o}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
